// File: rtl/seg7_scroller.sv
// Purpose: plays a message of 7-segment patterns from a local pattern memory, one character per period.
// Latency: outputs are registered and track state; first pattern is on segments the cycle after start is sampled.
// Backpressure: none; writes are accepted every cycle in any state, and stop/start take effect on the next edge.
module seg7_scroller #(
   parameter  int DEPTH = 32,
   parameter  int DIV_W = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [6:0]       wr_data,
   input  logic             start,
   input  logic             stop,
   input  logic [AW:0]      len,
   input  logic             loop,
   input  logic [DIV_W-1:0] div,
   output logic [6:0]       segments,
   output logic             dp,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    char_idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam logic [AW:0]      LEN_ONE = (AW+1)'(1);
   localparam logic [AW:0]      DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]    IDX_ONE = AW'(1);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   // pattern memory
   logic [6:0]       mem [DEPTH];

   // playback state and captured start parameters
   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q,   idx_d;
   logic [DIV_W-1:0] cnt_q,   cnt_d;
   logic [AW:0]      len_q,   len_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic             loop_q,  loop_d;
   logic             done_d;

   // registered display outputs, computed from the next state so they line up with char_idx
   logic [6:0]       seg_d;
   logic             dp_d;

   logic             tick;
   logic             start_ok;
   logic             kill;
   logic [AW:0]      len_clamp;
   logic [6:0]       rd_pat;

   // a character period ends when the counter reaches the captured divider
   assign tick      = (cnt_q == div_q);
   // a zero-length start cannot play anything; while running it is treated as an abort
   assign start_ok  = start && (len != '0);
   assign kill      = stop || (start && (len == '0) && (state_q != IDLE));
   // messages longer than the memory play the whole memory once per pass
   assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;

   // a same-cycle write to the index about to be shown is forwarded so it is visible immediately
   assign rd_pat    = (wr_en && (wr_addr == idx_d)) ? wr_data : mem[idx_d];

   assign busy      = (state_q != IDLE);
   assign char_idx  = idx_q;

   // pattern memory: cleared by reset, writable at any time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // state, index, period counter and captured parameters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         div_q   <= '0;
         loop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         div_q   <= div_d;
         loop_q  <= loop_d;
      end
   end

   // next-state logic: abort beats restart, restart beats normal sequencing
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      div_d   = div_q;
      loop_d  = loop_q;
      done_d  = 1'b0;

      if (kill) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (start_ok) begin
         state_d = SHOW;
         idx_d   = '0;
         cnt_d   = '0;
         len_d   = len_clamp;
         div_d   = div;
         loop_d  = loop;
      end else begin
         case (state_q)
            IDLE: begin
               idx_d = '0;
               cnt_d = '0;
            end
            SHOW: begin
               cnt_d = tick ? '0 : cnt_q + CNT_ONE;
               if (tick) begin
                  if ({1'b0, idx_q} == len_q - LEN_ONE) begin
                     // index holds on the last character through the blank period
                     state_d = BLANK;
                  end else begin
                     idx_d = idx_q + IDX_ONE;
                  end
               end
            end
            BLANK: begin
               cnt_d = tick ? '0 : cnt_q + CNT_ONE;
               if (tick) begin
                  idx_d = '0;
                  if (loop_q) begin
                     state_d = SHOW;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // display pattern and decimal point for the state being entered
   always_comb begin
      seg_d = 7'h00;
      dp_d  = 1'b0;
      if (state_d == SHOW) begin
         seg_d = rd_pat;
         dp_d  = ({1'b0, idx_d} == len_d - LEN_ONE);
      end
   end

   // output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= 7'h00;
         dp       <= 1'b0;
         done     <= 1'b0;
      end else begin
         segments <= seg_d;
         dp       <= dp_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_seg7_scroller.sv
module tb_seg7_scroller;

   localparam int DEPTH = 32;
   localparam int DIV_W = 16;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [6:0]       wr_data = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [AW:0]      len = '0;
   logic             loop = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic [6:0]       segments;
   logic             dp;
   logic             busy;
   logic             done;
   logic [AW-1:0]    char_idx;

   int checks = 0;
   int errors = 0;

   seg7_scroller #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .len(len), .loop(loop), .div(div),
      .segments(segments), .dp(dp), .busy(busy), .done(done), .char_idx(char_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a message is a walk through positions 0..len-1 followed by one
   // blank position (pos == len); each position is held for div+1 clocks.
   logic [6:0] m_mem [DEPTH];
   bit         m_act;
   int         m_pos, m_age, m_len, m_div;
   bit         m_loop;
   logic [6:0] e_seg;
   bit         e_dp, e_done, e_busy;
   int         e_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_mem[i]) m_mem[i] = 7'h00;
         m_act = 0; m_pos = 0; m_age = 0; m_len = 0; m_div = 0; m_loop = 0;
         e_done = 0;
      end else begin
         if (wr_en) m_mem[wr_addr] = wr_data;
         e_done = 0;
         if (stop || (start && len == 0 && m_act)) begin
            m_act = 0; m_pos = 0; m_age = 0;
         end else if (start && len != 0) begin
            m_act = 1; m_len = (len > DEPTH) ? DEPTH : int'(len);
            m_div = int'(div); m_loop = loop; m_pos = 0; m_age = 0;
         end else if (m_act) begin
            if (m_age == m_div) begin
               m_age = 0;
               m_pos++;
               if (m_pos > m_len) begin
                  if (m_loop) m_pos = 0;
                  else begin m_act = 0; m_pos = 0; e_done = 1; end
               end
            end else begin
               m_age++;
            end
         end
      end
      e_busy = m_act;
      e_idx  = !m_act ? 0 : ((m_pos == m_len) ? m_len - 1 : m_pos);
      e_seg  = (m_act && m_pos < m_len) ? m_mem[m_pos] : 7'h00;
      e_dp   = m_act && (m_pos == m_len - 1);
   end

   // compare every cycle while out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_segments", 32'(segments), 32'(e_seg));
         chk("m_dp",       32'(dp),       32'(e_dp));
         chk("m_busy",     32'(busy),     32'(e_busy));
         chk("m_done",     32'(done),     32'(e_done));
         chk("m_char_idx", 32'(char_idx), 32'(e_idx));
      end
   end

   task automatic wr(input int a, input logic [6:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic go(input int l, input int dv, input bit lp);
      start = 1'b1; len = (AW+1)'(l); div = DIV_W'(dv); loop = lp;
      @(negedge clk);
      start = 1'b0; len = '0; div = '0; loop = 1'b0;
   endtask

   initial begin
      logic [6:0] xs;
      repeat (3) @(negedge clk);
      chk("rst_segments", 32'(segments), 32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_done",     32'(done),     32'h0);
      chk("rst_dp",       32'(dp),       32'h0);
      chk("rst_char_idx", 32'(char_idx), 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // one-shot three-character message, four clocks per character
      wr(0, 7'h3D); wr(1, 7'h7B); wr(2, 7'h50);
      go(3, 3, 1'b0);
      for (int j = 0; j < 18; j++) begin
         xs = (j < 4) ? 7'h3D : (j < 8) ? 7'h7B : (j < 12) ? 7'h50 : 7'h00;
         chk("oneshot_seg",  32'(segments), 32'(xs));
         chk("oneshot_dp",   32'(dp),   32'((j >= 8 && j < 12) ? 1 : 0));
         chk("oneshot_busy", 32'(busy), 32'((j < 16) ? 1 : 0));
         chk("oneshot_done", 32'(done), 32'((j == 16) ? 1 : 0));
         @(negedge clk);
      end

      // zero-length start while idle is ignored
      go(0, 2, 1'b1);
      chk("len0_idle_busy", 32'(busy), 32'h0);

      // overlong message plays the whole memory, index never passes the top
      go(40, 0, 1'b0);
      for (int j = 0; j < 34; j++) begin
         chk("long_idx",  32'(char_idx), 32'((j < 32) ? j : (j == 32 ? 31 : 0)));
         chk("long_busy", 32'(busy), 32'((j < 33) ? 1 : 0));
         @(negedge clk);
      end

      // looping, one clock per character, then stop together with start
      go(3, 0, 1'b1);
      for (int j = 0; j < 8; j++) begin
         xs = (j % 4 == 0) ? 7'h3D : (j % 4 == 1) ? 7'h7B : (j % 4 == 2) ? 7'h50 : 7'h00;
         chk("loop_seg", 32'(segments), 32'(xs));
         @(negedge clk);
      end
      start = 1'b1; stop = 1'b1; len = 6'd3;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; len = '0;
      chk("stop_seg",  32'(segments), 32'h0);
      chk("stop_busy", 32'(busy), 32'h0);
      @(negedge clk);
      chk("stop_nodone", 32'(done), 32'h0);

      // reset during the blank period of a one-shot message
      go(2, 3, 1'b0);
      repeat (9) @(negedge clk);
      chk("pre_rst_blank", 32'(busy & (segments == 7'h00)), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_segments", 32'(segments), 32'h0);
      chk("arst_busy",     32'(busy),     32'h0);
      chk("arst_done",     32'(done),     32'h0);
      chk("arst_dp",       32'(dp),       32'h0);
      chk("arst_char_idx", 32'(char_idx), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_nodone", 32'(done), 32'h0);
      go(3, 0, 1'b0);
      for (int j = 0; j < 3; j++) begin
         chk("cleared_seg",  32'(segments), 32'h0);
         chk("cleared_busy", 32'(busy), 32'h1);
         @(negedge clk);
      end
      repeat (3) @(negedge clk);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = AW'($urandom);
         wr_data = 7'($urandom);
         start   = ($urandom_range(0, 39) == 0);
         stop    = ($urandom_range(0, 149) == 0);
         len     = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, 40));
         div     = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 9))
                                               : DIV_W'($urandom_range(0, 3));
         loop    = 1'($urandom);
         @(negedge clk);
      end
      wr_en = 1'b0; start = 1'b0; stop = 1'b0; len = '0; div = '0; loop = 1'b0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scroller.md
SEG7_SCROLLER -- requirements
Module: seg7_scroller

Interface
REQ-001 Parameter DEPTH, default 32, pattern memory entries; SHALL be a power of two, 2..256.
REQ-002 Parameter DIV_W, default 16, width of the character-period divider.
REQ-003 Derived AW = log2(DEPTH).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 wr_en  in  1  pattern memory write strobe.
REQ-007 wr_addr  in  AW  pattern memory write address.
REQ-008 wr_data  in  7  segment pattern; bit0=a top, bit1=b upper-right, bit2=c lower-right, bit3=d bottom, bit4=e lower-left, bit5=f upper-left, bit6=g middle.
REQ-009 start  in  1  begin or restart playback.
REQ-010 stop  in  1  abort playback.
REQ-011 len  in  AW+1  message length in characters, sampled on start.
REQ-012 loop  in  1  1 = repeat forever, 0 = one-shot; sampled on start.
REQ-013 div  in  DIV_W  character period minus one, in clk cycles; sampled on start.
REQ-014 segments  out  7  registered pattern, same bit map as wr_data, active-high.
REQ-015 dp  out  1  registered, high while the last character of the message is shown.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse at end of one-shot playback.
REQ-018 char_idx  out  AW  index of the character currently shown.

Function
REQ-019 Memory SHALL be DEPTH x 7 flops, written on clock edge when wr_en, in any state; a write to the displayed index SHALL appear on segments the following cycle.
REQ-020 FSM states: IDLE, SHOW, BLANK.
REQ-021 IDLE + start with len!=0: capture len_q=min(len,DEPTH), div_q, loop_q; idx=0; tick counter=0; go SHOW.
REQ-022 start with len==0 SHALL be ignored in IDLE; in SHOW/BLANK it SHALL act as stop.
REQ-023 start in SHOW/BLANK with len!=0 SHALL restart exactly as REQ-021.
REQ-024 stop SHALL have priority over start: go IDLE, idx=0, no done pulse.
REQ-025 Tick counter counts 0..div_q in SHOW/BLANK; tick asserted when count==div_q, counter then wraps to 0; each character lasts div_q+1 cycles; div_q=0 gives one cycle per character.
REQ-026 SHOW on tick: idx==len_q-1 -> BLANK, else idx+1.
REQ-027 BLANK lasts one character period; on tick: loop_q=1 -> SHOW, idx=0; loop_q=0 -> IDLE, done=1 for one cycle.
REQ-028 segments SHALL equal mem[idx] one cycle after entering/being in SHOW, 7'h00 in IDLE and BLANK; latency start->first pattern is 1 cycle.
REQ-029 dp SHALL be 1 in SHOW when idx==len_q-1, else 0.
REQ-030 char_idx SHALL equal idx; 0 in IDLE.
REQ-031 Inputs len, loop, div SHALL have no effect except on an accepted start.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, idx=0, counter=0, all memory entries 0, segments=0, dp=0, busy=0, done=0.
REQ-033 Reset mid-playback SHALL abort without a done pulse; first start after release behaves as REQ-021.

Verification
REQ-034 Write mem[0..2]=7'h3D,7'h7B,7'h50; start len=3 div=3 loop=0 -> segments 3D,7B,50 for 4 cycles each, dp high only during 50, 4 cycles of 00, done one cycle, busy low after.
REQ-035 Same with loop=1, div=0 -> repeating 3D,7B,50,00 every cycle; stop asserted together with start mid-run -> IDLE, segments 00, no done.
REQ-036 len=40 with DEPTH=32 -> plays indices 0..31 then blank; char_idx wraps 31->BLANK, never exceeds 31.
REQ-037 During SHOW of idx 1 with div=7, write mem[1]=7'h77 -> segments 77 next cycle, period unchanged.
REQ-038 Restart at idx 2 with new div=1 -> idx 0 one cycle later, 2-cycle periods; start with len=0 while IDLE -> busy stays 0.
REQ-039 rst_n low for 1 cycle mid-BLANK, loop=0 -> all outputs 0 asynchronously, memory cleared, no done pulse.
